// File: rtl/adc_event_builder.sv
// Digital discriminator on the ADC stream: finds threshold crossings, tracks the pulse
// peak and emits one {peak, timestamp} word per pulse as a single-cycle FIFO write strobe.
module adc_event_builder #(
  parameter int ADC_W   = 14,
  parameter int TS_W    = 50,
  parameter int TS_STEP = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ts_clear,
  input  logic [ADC_W-1:0] adc_in,
  input  logic [ADC_W-1:0] threshold,
  input  logic [ADC_W-1:0] hysteresis,
  input  logic [CNT_W-1:0] peak_window,
  input  logic [CNT_W-1:0] holdoff,
  input  logic             event_ready,
  output logic [63:0]      event_data,
  output logic             event_valid,
  output logic [31:0]      drop_count,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, ARMED, PEAK, EMIT, HOLDOFF} state_t;

  state_t                  state_reg, state_next;
  logic signed [ADC_W-1:0] s_reg, s_prev_reg;
  logic signed [ADC_W-1:0] peak_reg, peak_next;
  logic [TS_W-1:0]         ts_reg, ts_evt_reg, ts_evt_next;
  logic [CNT_W-1:0]        wcnt_reg, wcnt_next, hcnt_reg, hcnt_next;
  logic [63:0]             event_data_reg;
  logic                    event_valid_reg;
  logic [31:0]             drop_count_reg;

  logic signed [ADC_W-1:0] thr, rearm;
  logic [ADC_W+1:0]        rearm_wide;
  logic                    crossing, emit_ok;

  assign thr = threshold;

  // Two guard bits so threshold - hysteresis can never wrap before saturation.
  assign rearm_wide = {{2{threshold[ADC_W-1]}}, threshold} - {2'b00, hysteresis};
  always_comb begin
    rearm = rearm_wide[ADC_W-1:0];
    if (rearm_wide[ADC_W+1:ADC_W-1] != 3'b000 && rearm_wide[ADC_W+1:ADC_W-1] != 3'b111)
      rearm = {1'b1, {(ADC_W-1){1'b0}}};
  end

  assign crossing = (s_reg > thr) && (s_prev_reg <= thr);
  assign emit_ok  = (state_reg == EMIT) && enable;

  always_comb begin
    state_next  = state_reg;
    peak_next   = peak_reg;
    wcnt_next   = wcnt_reg;
    hcnt_next   = hcnt_reg;
    ts_evt_next = ts_evt_reg;
    case (state_reg)
      IDLE:    if (s_reg <= thr) state_next = ARMED;
      ARMED: begin
        if (crossing) begin
          ts_evt_next = ts_reg;
          peak_next   = s_reg;
          wcnt_next   = CNT_W'(1);
          state_next  = PEAK;
        end
      end
      PEAK: begin
        if (s_reg > peak_reg) peak_next = s_reg;
        wcnt_next = wcnt_reg + CNT_W'(1);
        // wcnt starts at 1, so a zero window closes after one cycle just like a window of 1.
        if (wcnt_reg >= peak_window || s_reg < rearm) state_next = EMIT;
      end
      EMIT: begin
        hcnt_next  = holdoff;
        state_next = HOLDOFF;
      end
      HOLDOFF: begin
        if (hcnt_reg != '0)    hcnt_next = hcnt_reg - CNT_W'(1);
        else if (s_reg < rearm) state_next = ARMED;
      end
      default: state_next = IDLE;
    endcase
    if (!enable) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      s_reg           <= '0;
      s_prev_reg      <= '0;
      peak_reg        <= '0;
      ts_reg          <= '0;
      ts_evt_reg      <= '0;
      wcnt_reg        <= '0;
      hcnt_reg        <= '0;
      event_data_reg  <= '0;
      event_valid_reg <= 1'b0;
      drop_count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      s_reg      <= adc_in;
      s_prev_reg <= s_reg;
      peak_reg   <= peak_next;
      ts_evt_reg <= ts_evt_next;
      wcnt_reg   <= wcnt_next;
      hcnt_reg   <= hcnt_next;
      ts_reg     <= ts_clear ? '0 : ts_reg + TS_W'(TS_STEP);
      event_valid_reg <= emit_ok && event_ready;
      if (emit_ok && event_ready) event_data_reg <= {peak_reg, ts_evt_reg};
      if (emit_ok && !event_ready && drop_count_reg != 32'hFFFF_FFFF)
        drop_count_reg <= drop_count_reg + 32'd1;
    end
  end

  assign event_data  = event_data_reg;
  assign event_valid = event_valid_reg;
  assign drop_count  = drop_count_reg;
  assign busy        = (state_reg == PEAK) || (state_reg == EMIT) || (state_reg == HOLDOFF);

endmodule

// File: tb/tb_adc_event_builder.sv
// Directed bench for adc_event_builder: single pulse, window cut, holdoff, backpressure,
// enable/reset abort and timestamp clear, each with hand-computed expected event words.
module tb_adc_event_builder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        ts_clear;
  logic [13:0] adc_in;
  logic [13:0] threshold;
  logic [13:0] hysteresis;
  logic [15:0] peak_window;
  logic [15:0] holdoff;
  logic        event_ready;
  logic [63:0] event_data;
  logic        event_valid;
  logic [31:0] drop_count;
  logic        busy;

  int          errors = 0;
  int          checks = 0;
  int          ev_cnt = 0;
  logic [63:0] last_data = '0;
  logic [63:0] prev_data = '0;
  longint      cyc;

  adc_event_builder dut (
    .clk(clk), .reset(reset), .enable(enable), .ts_clear(ts_clear), .adc_in(adc_in),
    .threshold(threshold), .hysteresis(hysteresis), .peak_window(peak_window),
    .holdoff(holdoff), .event_ready(event_ready), .event_data(event_data),
    .event_valid(event_valid), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the timestamp after N edges is 8*N when never cleared.
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  always @(negedge clk)
    if (event_valid) begin
      ev_cnt++;
      prev_data = last_data;
      last_data = event_data;
      $display("event %0d: peak=%0d ts=%0d", ev_cnt, $signed(event_data[63:50]), event_data[49:0]);
    end

  function automatic logic [63:0] mk(input int pk, input longint ts);
    logic [13:0] p;
    logic [49:0] t;
    p = 14'(pk);
    t = 50'(ts);
    return {p, t};
  endfunction

  task automatic put(input int v);
    adc_in = 14'(v);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input int pk, input int hi, input int lo, output longint tsx);
    tsx = 8 * (cyc + 1);
    repeat (hi) put(pk);
    repeat (lo) put(0);
  endtask

  task automatic cfg(input int pw, input int ho);
    enable = 1'b0;
    put(0);
    threshold   = 14'd1000;
    hysteresis  = 14'd100;
    peak_window = 16'(pw);
    holdoff     = 16'(ho);
    enable = 1'b1;
    repeat (3) put(0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", event_valid); end
    checks++; if (event_data !== 64'd0) begin errors++; $display("FAIL rst_data got=%h exp=0", event_data); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL rst_drop got=%0d exp=0", drop_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    reset = 1'b0;
    repeat (2) put(0);
    checks++; if (event_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_release got=%b%b exp=00", event_valid, busy); end
  endtask

  task automatic test_single_pulse;
    int     c0;
    longint tsx;
    cfg(8, 0);
    c0  = ev_cnt;
    tsx = 8 * (cyc + 1);
    put(1200); put(1500); put(1800); put(1600); put(900); put(0);
    repeat (10) put(0);
    checks++; if (ev_cnt !== c0 + 1) begin errors++; $display("FAIL single_count got=%0d exp=%0d", ev_cnt, c0 + 1); end
    checks++; if (last_data !== mk(1800, tsx)) begin errors++; $display("FAIL single_data got=%h exp=%h", last_data, mk(1800, tsx)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", busy); end
  endtask

  task automatic test_window_cut;
    int     c0;
    longint tsx, tsy;
    cfg(3, 0);
    c0  = ev_cnt;
    tsx = 8 * (cyc + 1);
    put(2000);
    repeat (4) put(2000);
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL win_early got=%b exp=0", event_valid); end
    put(2000);
    checks++; if (event_valid !== 1'b1) begin errors++; $display("FAIL win_latency got=%b exp=1", event_valid); end
    put(2000);
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL win_one_cycle got=%b exp=0", event_valid); end
    repeat (13) put(2000);
    checks++; if (ev_cnt !== c0 + 1) begin errors++; $display("FAIL win_count got=%0d exp=%0d", ev_cnt, c0 + 1); end
    checks++; if (last_data !== mk(2000, tsx)) begin errors++; $display("FAIL win_data got=%h exp=%h", last_data, mk(2000, tsx)); end
    repeat (3) put(0);
    pulse(2000, 5, 10, tsy);
    checks++; if (ev_cnt !== c0 + 2) begin errors++; $display("FAIL win_recross got=%0d exp=%0d", ev_cnt, c0 + 2); end
    checks++; if (last_data !== mk(2000, tsy)) begin errors++; $display("FAIL win_recross_data got=%h exp=%h", last_data, mk(2000, tsy)); end
  endtask

  task automatic test_holdoff;
    int     c0;
    longint ta, tb, tc, td;
    cfg(4, 50);
    c0 = ev_cnt;
    pulse(2000, 3, 17, ta);
    pulse(2000, 3, 80, tb);
    checks++; if (ev_cnt !== c0 + 1) begin errors++; $display("FAIL hold_20_count got=%0d exp=%0d", ev_cnt, c0 + 1); end
    checks++; if (last_data !== mk(2000, ta)) begin errors++; $display("FAIL hold_20_data got=%h exp=%h", last_data, mk(2000, ta)); end
    pulse(2000, 3, 57, tc);
    pulse(2000, 3, 80, td);
    checks++; if (ev_cnt !== c0 + 3) begin errors++; $display("FAIL hold_60_count got=%0d exp=%0d", ev_cnt, c0 + 3); end
    checks++; if (prev_data !== mk(2000, tc)) begin errors++; $display("FAIL hold_60_first got=%h exp=%h", prev_data, mk(2000, tc)); end
    checks++; if (last_data[49:0] - prev_data[49:0] !== 50'd480) begin errors++; $display("FAIL hold_60_delta got=%0d exp=480", last_data[49:0] - prev_data[49:0]); end
  endtask

  task automatic test_backpressure;
    int     c0;
    longint t;
    cfg(4, 0);
    c0 = ev_cnt;
    event_ready = 1'b0;
    repeat (3) pulse(2000, 3, 10, t);
    checks++; if (ev_cnt !== c0) begin errors++; $display("FAIL bp_novalid got=%0d exp=%0d", ev_cnt, c0); end
    checks++; if (drop_count !== 32'd3) begin errors++; $display("FAIL bp_drop got=%0d exp=3", drop_count); end
    event_ready = 1'b1;
    pulse(1500, 3, 10, t);
    checks++; if (ev_cnt !== c0 + 1) begin errors++; $display("FAIL bp_resume got=%0d exp=%0d", ev_cnt, c0 + 1); end
    checks++; if (last_data !== mk(1500, t)) begin errors++; $display("FAIL bp_data got=%h exp=%h", last_data, mk(1500, t)); end
    checks++; if (drop_count !== 32'd3) begin errors++; $display("FAIL bp_drop_hold got=%0d exp=3", drop_count); end
  endtask

  task automatic test_enable_abort;
    int     c0;
    longint t;
    cfg(8, 0);
    c0 = ev_cnt;
    put(2000); put(2000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_busy_peak got=%b exp=1", busy); end
    enable = 1'b0;
    put(2000);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_busy_drop got=%b exp=0", busy); end
    enable = 1'b1;
    repeat (12) put(2000);
    checks++; if (ev_cnt !== c0 || busy !== 1'b0) begin errors++; $display("FAIL en_high_noevent got=%0d/%b exp=%0d/0", ev_cnt, busy, c0); end
    repeat (3) put(0);
    pulse(1700, 3, 12, t);
    checks++; if (ev_cnt !== c0 + 1) begin errors++; $display("FAIL en_fresh_count got=%0d exp=%0d", ev_cnt, c0 + 1); end
    checks++; if (last_data !== mk(1700, t)) begin errors++; $display("FAIL en_fresh_data got=%h exp=%h", last_data, mk(1700, t)); end
  endtask

  task automatic test_reset_mid_pulse;
    int c0;
    cfg(8, 0);
    c0 = ev_cnt;
    put(2000); put(2000);
    reset = 1'b1;
    #1;
    checks++; if (event_data !== 64'd0 || event_valid !== 1'b0) begin errors++; $display("FAIL rmid_data got=%h/%b exp=0/0", event_data, event_valid); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL rmid_drop got=%0d exp=0", drop_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (15) put(0);
    checks++; if (ev_cnt !== c0) begin errors++; $display("FAIL rmid_partial got=%0d exp=%0d", ev_cnt, c0); end
  endtask

  task automatic test_ts_clear;
    int c0;
    cfg(2, 0);
    c0 = ev_cnt;
    ts_clear = 1'b1;
    put(0);
    ts_clear = 1'b0;
    repeat (9) put(0);
    put(2000);
    ts_clear = 1'b1;
    put(2000);
    ts_clear = 1'b0;
    put(2000);
    repeat (20) put(0);
    put(2000); put(2000); put(2000);
    repeat (10) put(0);
    checks++; if (ev_cnt !== c0 + 2) begin errors++; $display("FAIL ts_count got=%0d exp=%0d", ev_cnt, c0 + 2); end
    checks++; if (prev_data !== mk(2000, 80)) begin errors++; $display("FAIL ts_after_clear got=%h exp=%h", prev_data, mk(2000, 80)); end
    checks++; if (last_data !== mk(2000, 176)) begin errors++; $display("FAIL ts_clear_on_cross got=%h exp=%h", last_data, mk(2000, 176)); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; ts_clear = 1'b0; adc_in = '0;
    threshold = 14'd1000; hysteresis = 14'd100; peak_window = 16'd8; holdoff = 16'd0;
    event_ready = 1'b1;
    test_reset;
    test_single_pulse;
    test_window_cut;
    test_holdoff;
    test_backpressure;
    test_enable_abort;
    test_reset_mid_pulse;
    test_ts_clear;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
